// File: rtl/exec_ram_pkg.sv
// Shared types and address helpers for the execution-unit RAM responder.
package exec_ram_pkg;

    localparam int unsigned WORD_BYTES       = 4;
    localparam int unsigned MAX_READ_LATENCY = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rd_resp_t;

    function automatic logic addr_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> (aw + 2)) == '0;
    endfunction

    function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return (addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Fixed-depth delay line of read responses; each stage keeps its last valid data
// so the output data holds between responses.
module ram_read_pipe
    import exec_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  rd_resp_t resp_i,
    output rd_resp_t resp_o
);

    rd_resp_t stage_q [DEPTH];
    rd_resp_t stage_d [DEPTH];

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        stage_d[0].valid = resp_i.valid;
        if (resp_i.valid) begin
            stage_d[0].data = resp_i.data;
        end
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i].valid = stage_q[i-1].valid;
            if (stage_q[i-1].valid) begin
                stage_d[i].data = stage_q[i-1].data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign resp_o = stage_q[DEPTH-1];

endmodule

// File: rtl/exec_ram_responder.sv
// Word RAM serving instruction-fetch reads and store writes, with write-first
// forwarding, fixed read latency and sticky address-error flags.
module exec_ram_responder
    import exec_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_ram_en,
    input  logic [31:0] rd_ram_addr,
    output logic [31:0] rd_ram_data,
    output logic        rd_ram_valid,
    input  logic        wr_ram_en,
    input  logic [31:0] wr_ram_addr,
    input  logic [31:0] wr_ram_data,
    input  logic        err_clear,
    output logic        err_misaligned,
    output logic        err_range
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("exec_ram_responder: READ_LATENCY must be 1..4");
    end

    logic [31:0] mem_q [DEPTH];

    logic                  rd_aligned, rd_in_range, rd_legal;
    logic                  wr_aligned, wr_in_range, wr_legal;
    logic [ADDR_WIDTH-1:0] rd_idx, wr_idx;
    rd_resp_t              rd_req, rd_resp;
    logic                  err_mis_q, err_mis_d, err_rng_q, err_rng_d;

    assign rd_aligned  = addr_aligned(rd_ram_addr);
    assign rd_in_range = addr_in_range(rd_ram_addr, ADDR_WIDTH);
    assign rd_legal    = rd_aligned && rd_in_range;
    assign rd_idx      = ADDR_WIDTH'(word_index(rd_ram_addr, ADDR_WIDTH));

    assign wr_aligned  = addr_aligned(wr_ram_addr);
    assign wr_in_range = addr_in_range(wr_ram_addr, ADDR_WIDTH);
    assign wr_legal    = wr_aligned && wr_in_range;
    assign wr_idx      = ADDR_WIDTH'(word_index(wr_ram_addr, ADDR_WIDTH));

    // Reset only blocks writes; the array itself is never cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (reset_n && wr_ram_en && wr_legal) begin
            mem_q[wr_idx] <= wr_ram_data;
        end
    end

    always_comb begin
        rd_req.valid = rd_ram_en;
        rd_req.data  = '0;
        if (rd_legal) begin
            if (wr_ram_en && wr_legal && (wr_idx == rd_idx)) begin
                rd_req.data = wr_ram_data;
            end else begin
                rd_req.data = mem_q[rd_idx];
            end
        end
    end

    ram_read_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_pipe (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .resp_i (rd_req),
        .resp_o (rd_resp)
    );

    assign rd_ram_valid = rd_resp.valid;
    assign rd_ram_data  = rd_resp.data;

    // A new offending access outranks a simultaneous clear.
    always_comb begin
        err_mis_d = (err_mis_q && !err_clear)
                  || (rd_ram_en && !rd_aligned) || (wr_ram_en && !wr_aligned);
        err_rng_d = (err_rng_q && !err_clear)
                  || (rd_ram_en && !rd_in_range) || (wr_ram_en && !wr_in_range);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_mis_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            err_mis_q <= err_mis_d;
            err_rng_q <= err_rng_d;
        end
    end

    assign err_misaligned = err_mis_q;
    assign err_range      = err_rng_q;

endmodule

// File: tb/tb_exec_ram_responder.sv
// Bench for exec_ram_responder: latency-1 and latency-3 instances share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_exec_ram_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        clr = 1'b0;

    logic [31:0] d1, d3;
    logic        v1, v3, em1, em3, er1, er3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_ram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .rd_ram_en(rd_en), .rd_ram_addr(rd_addr), .rd_ram_data(d1), .rd_ram_valid(v1),
        .wr_ram_en(wr_en), .wr_ram_addr(wr_addr), .wr_ram_data(wr_data),
        .err_clear(clr), .err_misaligned(em1), .err_range(er1)
    );

    exec_ram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(3)) u3 (
        .clk(clk), .reset_n(reset_n),
        .rd_ram_en(rd_en), .rd_ram_addr(rd_addr), .rd_ram_data(d3), .rd_ram_valid(v3),
        .wr_ram_en(wr_en), .wr_ram_addr(wr_addr), .wr_ram_data(wr_data),
        .err_clear(clr), .err_misaligned(em3), .err_range(er3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 1024-word array, byte addresses below 4096 that are multiples of 4.
    logic [31:0] mmem [1024];
    logic        acc_v [$];
    logic [31:0] acc_d [$];
    logic [31:0] last1 = '0, last3 = '0, rdv;
    logic        exp_em = 1'b0, exp_er = 1'b0, ev1, ev3;

    function automatic logic legal(input logic [31:0] a);
        return (a < 32'h1000) && (a % 4 == 0);
    endfunction

    function automatic logic mis(input logic [31:0] a);
        return a % 4 != 0;
    endfunction

    function automatic logic oor(input logic [31:0] a);
        return a >= 32'h1000;
    endfunction

    always @(negedge reset_n) begin
        acc_v.delete();
        acc_d.delete();
        last1  = '0;
        last3  = '0;
        exp_em = 1'b0;
        exp_er = 1'b0;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            rdv = '0;
            if (legal(rd_addr)) begin
                if (wr_en && legal(wr_addr) && wr_addr == rd_addr) rdv = wr_data;
                else rdv = mmem[rd_addr / 4];
            end
            acc_v.push_back(rd_en);
            acc_d.push_back(rdv);
            if (wr_en && legal(wr_addr)) mmem[wr_addr / 4] = wr_data;
            exp_em = (rd_en && mis(rd_addr)) || (wr_en && mis(wr_addr)) || (exp_em && !clr);
            exp_er = (rd_en && oor(rd_addr)) || (wr_en && oor(wr_addr)) || (exp_er && !clr);
        end
        #1;
        // response accepted at edge k appears after edge k+L-1
        ev1 = 1'b0;
        if (acc_v.size() >= 1 && acc_v[acc_v.size() - 1]) begin
            ev1   = 1'b1;
            last1 = acc_d[acc_d.size() - 1];
        end
        ev3 = 1'b0;
        if (acc_v.size() >= 3 && acc_v[acc_v.size() - 3]) begin
            ev3   = 1'b1;
            last3 = acc_d[acc_d.size() - 3];
        end
        chk("m_valid_L1", 32'(v1), 32'(ev1));
        chk("m_data_L1", d1, last1);
        chk("m_valid_L3", 32'(v3), 32'(ev3));
        chk("m_data_L3", d3, last3);
        chk("m_err_mis_L1", 32'(em1), 32'(exp_em));
        chk("m_err_rng_L1", 32'(er1), 32'(exp_er));
        chk("m_err_mis_L3", 32'(em3), 32'(exp_em));
        chk("m_err_rng_L3", 32'(er3), 32'(exp_er));
    end

    task automatic step(input logic re, input logic [31:0] ra, input logic we,
                        input logic [31:0] wa, input logic [31:0] wd, input logic c);
        rd_en   = re;
        rd_addr = ra;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        clr     = c;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r < 16) return 32'($urandom_range(0, 15) * 4);
        if (r < 18) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        if (r == 18) return 32'h1000 + 32'($urandom_range(0, 255) * 4);
        return $urandom | 32'h8000_0000;
    endfunction

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(v1), 0);
        chk("reset_data", d3, 0);
        chk("reset_err", 32'({em1, er1, em3, er3}), 0);
        reset_n = 1'b1;

        for (int w = 0; w < 16; w++) step(1'b0, '0, 1'b1, 32'(w * 4), 32'h1000_0000 + 32'(w), 1'b0);

        // write then read, latency 1
        step(1'b0, '0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        step(1'b1, 32'h10, 1'b0, '0, '0, 1'b0);
        chk("t1_valid", 32'(v1), 1);
        chk("t1_data", d1, 32'hDEADBEEF);
        idle();
        chk("t1_valid_drop", 32'(v1), 0);

        // write-first forwarding
        step(1'b1, 32'h20, 1'b1, 32'h20, 32'h0000_1234, 1'b0);
        chk("t2_fwd", d1, 32'h0000_1234);
        step(1'b1, 32'h20, 1'b0, '0, '0, 1'b0);
        chk("t2_later", d1, 32'h0000_1234);

        // latency 3 back-to-back with a write behind an in-flight read
        step(1'b0, '0, 1'b1, 32'h0, 32'd1, 1'b0);
        step(1'b0, '0, 1'b1, 32'h4, 32'd2, 1'b0);
        step(1'b0, '0, 1'b1, 32'h8, 32'd3, 1'b0);
        step(1'b1, 32'h0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 32'h4, 1'b0, '0, '0, 1'b0);
        step(1'b1, 32'h8, 1'b1, 32'h4, 32'd9, 1'b0);
        chk("t3_d0", d3, 32'd1);
        idle();
        chk("t3_d1_frozen", d3, 32'd2);
        idle();
        chk("t3_d2", d3, 32'd3);
        idle();
        chk("t3_valid_end", 32'(v3), 0);
        step(1'b1, 32'h4, 1'b0, '0, '0, 1'b0);
        idle();
        idle();
        chk("t3_new_read", d3, 32'd9);

        // misaligned accesses and clear priority
        step(1'b0, '0, 1'b1, 32'h12, 32'h0000_FFFF, 1'b0);
        chk("t4_mis_set", 32'(em1), 1);
        step(1'b1, 32'h10, 1'b0, '0, '0, 1'b0);
        chk("t4_word_kept", d1, 32'hDEADBEEF);
        step(1'b1, 32'h13, 1'b0, '0, '0, 1'b0);
        chk("t4_mis_rd_valid", 32'(v1), 1);
        chk("t4_mis_rd_data", d1, 0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        chk("t4_cleared", 32'(em1), 0);
        step(1'b1, 32'h11, 1'b0, '0, '0, 1'b1);
        chk("t4_new_wins", 32'(em1), 1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);

        // out of range write
        step(1'b0, '0, 1'b1, 32'h1000, 32'h0000_A5A5, 1'b0);
        chk("t5_rng", 32'(er1), 1);
        chk("t5_mis", 32'(em1), 0);
        step(1'b1, 32'h0, 1'b0, '0, '0, 1'b0);
        chk("t5_word0_kept", d1, 32'd1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);

        // async reset with reads in flight
        step(1'b1, 32'h20, 1'b0, '0, '0, 1'b0);
        step(1'b1, 32'h10, 1'b0, '0, '0, 1'b0);
        rd_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_v1", 32'(v1), 0);
        chk("t6_async_d1", d1, 0);
        chk("t6_async_v3", 32'(v3), 0);
        chk("t6_async_d3", d3, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) idle();
        chk("t6_no_ghost", 32'(v3), 0);
        step(1'b1, 32'h10, 1'b0, '0, '0, 1'b0);
        idle();
        idle();
        chk("t6_mem_kept_v", 32'(v3), 1);
        chk("t6_mem_kept_d", d3, 32'hDEADBEEF);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            step(($urandom_range(0, 3) != 0), rand_addr(),
                 ($urandom_range(0, 2) == 0), rand_addr(), $urandom,
                 ($urandom_range(0, 9) == 0));
        end
        repeat (4) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
